// File: rtl/reaction_round_ctrl_pkg.sv
// reaction_pkg: shared types and constants for the reaction-game round sequencer.
//   RESULT_W  : width of all millisecond quantities (result, best, ms counter)
//   SIM_TICK  : clocks per ms tick when SIM_MODE=1
//   BEST_INIT : "no best yet" value held in oBEST_MS after reset
//   state_t   : round sequencer states IDLE -> ARM -> WAIT -> GO -> DONE
package reaction_pkg;

  localparam int unsigned RESULT_W = 14;
  localparam int unsigned SIM_TICK = 10;

  typedef logic [RESULT_W-1:0] ms_t;

  localparam ms_t BEST_INIT = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_GO,
    ST_DONE
  } state_t;

endpackage

// File: rtl/reaction_round_ctrl_if.sv
// reaction_round_ctrl_if: button/delay-block/display signals of the round sequencer.
//   slave  : sequencer side (takes iSTART, iREACT, iDELAY_DONE; drives all o* signals)
//   master : environment side (buttons, delay block, display)
interface reaction_round_ctrl_if;
  import reaction_pkg::*;

  logic iSTART;
  logic iREACT;
  logic iDELAY_DONE;
  logic oDELAY_EN;
  logic oDELAY_RST;
  logic oLED;
  logic oBUSY;
  ms_t  oRESULT_MS;
  logic oRESULT_VALID;
  logic oFALSE_START;
  logic oTIMEOUT;
  ms_t  oBEST_MS;

  modport slave (
    input  iSTART, iREACT, iDELAY_DONE,
    output oDELAY_EN, oDELAY_RST, oLED, oBUSY, oRESULT_MS,
           oRESULT_VALID, oFALSE_START, oTIMEOUT, oBEST_MS
  );

  modport master (
    output iSTART, iREACT, iDELAY_DONE,
    input  oDELAY_EN, oDELAY_RST, oLED, oBUSY, oRESULT_MS,
           oRESULT_VALID, oFALSE_START, oTIMEOUT, oBEST_MS
  );
endinterface

// File: rtl/reaction_round_ctrl_ms_tick_gen.sv
// ms_tick_gen: clock prescaler producing a one-cycle tick every DIV clocks.
//   iCLK  : system clock
//   iRST  : asynchronous active-high reset (counter to 0)
//   iCLR  : synchronous clear; holds the counter at 0 and suppresses the tick
//   oTICK : high on the terminal-count cycle (count == DIV-1)
module ms_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iCLR,
  output logic oTICK
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term = (r_cnt == TERM);
  assign oTICK  = w_term && !iCLR;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_cnt <= '0;
    end else if (iCLR || w_term) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/reaction_round_ctrl.sv
// reaction_round_ctrl: round sequencer for the reaction game.
// Arms the random-delay block on a start press, lights GO when the delay
// completes, then measures the reaction time in whole ms. Early presses
// abort the round (false start); no press within TIMEOUT_MS ends it with
// a saturated result and the timeout flag.
//   iCLK, iRST : clock, asynchronous active-high reset
//   bus.iSTART, bus.iREACT   : one-cycle button pulses
//   bus.iDELAY_DONE          : random delay elapsed
//   bus.oDELAY_EN/oDELAY_RST : one-cycle arm / abort pulses to the delay block
//   bus.oLED                 : GO stimulus
//   bus.oBUSY                : round in progress
//   bus.oRESULT_MS/VALID     : reaction time, one-cycle valid at round end
//   bus.oFALSE_START/TIMEOUT : sticky outcome flags, cleared on ARM
//   bus.oBEST_MS             : best valid result since reset
// Optional feature macro: REACTION_BEST_SCORE_EN (best-score register;
// when undefined oBEST_MS is tied to all ones).
// TIMEOUT_MS must not exceed 16383.
module reaction_round_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned SIM_MODE   = 0,
  parameter int unsigned TICK_DIV   = 50_000,
  parameter int unsigned TIMEOUT_MS = 999
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  reaction_round_ctrl_if.slave  bus
);
  localparam int unsigned DIV       = (SIM_MODE != 0) ? SIM_TICK : TICK_DIV;
  localparam ms_t         TIMEOUT_V = ms_t'(TIMEOUT_MS);

  state_t r_state;
  ms_t    r_ms;
  ms_t    r_result;
  logic   r_delay_en;
  logic   r_delay_rst;
  logic   r_led;
  logic   r_busy;
  logic   r_valid;
  logic   r_false_start;
  logic   r_timeout;
  logic   w_tick;
  logic   w_clr;

  // Prescaler is held cleared outside GO, so the first GO cycle starts at 0.
  assign w_clr = (r_state != ST_GO);

  ms_tick_gen #(.DIV(DIV)) u_tick (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iCLR  (w_clr),
    .oTICK (w_tick)
  );

`ifdef REACTION_BEST_SCORE_EN
  ms_t r_best;
  assign bus.oBEST_MS = r_best;
`else
  assign bus.oBEST_MS = BEST_INIT;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state       <= ST_IDLE;
      r_ms          <= '0;
      r_result      <= '0;
      r_delay_en    <= 1'b0;
      r_delay_rst   <= 1'b0;
      r_led         <= 1'b0;
      r_busy        <= 1'b0;
      r_valid       <= 1'b0;
      r_false_start <= 1'b0;
      r_timeout     <= 1'b0;
`ifdef REACTION_BEST_SCORE_EN
      r_best        <= BEST_INIT;
`endif
    end else begin
      r_delay_en  <= 1'b0;
      r_delay_rst <= 1'b0;
      r_valid     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.iSTART) begin
            r_state       <= ST_ARM;
            r_delay_en    <= 1'b1;
            r_busy        <= 1'b1;
            r_result      <= '0;
            r_false_start <= 1'b0;
            r_timeout     <= 1'b0;
          end
        end
        ST_ARM: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A press in the same cycle as delay done still counts as early.
          if (bus.iREACT) begin
            r_state       <= ST_DONE;
            r_false_start <= 1'b1;
            r_delay_rst   <= 1'b1;
            r_valid       <= 1'b1;
            r_result      <= '0;
          end else if (bus.iDELAY_DONE) begin
            r_state <= ST_GO;
            r_led   <= 1'b1;
            r_ms    <= '0;
          end
        end
        ST_GO: begin
          if (w_tick && (r_ms != TIMEOUT_V)) begin
            r_ms <= r_ms + ms_t'(1);
          end
          // Press wins over timeout when both land on the same cycle.
          if (bus.iREACT) begin
            r_state  <= ST_DONE;
            r_led    <= 1'b0;
            r_valid  <= 1'b1;
            r_result <= r_ms;
          end else if (r_ms == TIMEOUT_V) begin
            r_state   <= ST_DONE;
            r_led     <= 1'b0;
            r_valid   <= 1'b1;
            r_timeout <= 1'b1;
            r_result  <= TIMEOUT_V;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
`ifdef REACTION_BEST_SCORE_EN
          if (!r_false_start && !r_timeout && (r_result < r_best)) begin
            r_best <= r_result;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_led   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oDELAY_EN     = r_delay_en;
  assign bus.oDELAY_RST    = r_delay_rst;
  assign bus.oLED          = r_led;
  assign bus.oBUSY         = r_busy;
  assign bus.oRESULT_MS    = r_result;
  assign bus.oRESULT_VALID = r_valid;
  assign bus.oFALSE_START  = r_false_start;
  assign bus.oTIMEOUT      = r_timeout;
endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl (SIM_MODE=1: 10 clocks per ms, TIMEOUT_MS=999).
// Round records hold the stimulus (delay length, press mode, press offset in GO)
// and the hand-computed outcome; extra sequences cover reset and ignored inputs.
module tb_reaction_round_ctrl;
  import reaction_pkg::*;

  localparam int BEST_NONE = 16383;
`ifdef REACTION_BEST_SCORE_EN
  localparam bit BEST_ON = 1'b1;
`else
  localparam bit BEST_ON = 1'b0;
`endif

  // mode: 0 press r clocks after GO, 1 false start, 2 false start with
  // delay done in the same cycle, 3 no press (timeout)
  typedef struct {
    int d;
    int mode;
    int r;
    int exp_res;
    int exp_fs;
    int exp_to;
    int exp_best;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cur = 0;

  always #5 clk = ~clk;

  reaction_round_ctrl_if bus ();

  reaction_round_ctrl #(
    .SIM_MODE   (1),
    .TICK_DIV   (50_000),
    .TIMEOUT_MS (999)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL r%0d %s: got %0d expected %0d", cur, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.oDELAY_EN && bus.oDELAY_RST) begin
      failures++;
      $display("FAIL r%0d en_rst_overlap: got 1 expected 0", cur);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_outputs();
    chk("rst_led", bus.oLED, 0);
    chk("rst_busy", bus.oBUSY, 0);
    chk("rst_valid", bus.oRESULT_VALID, 0);
    chk("rst_en", bus.oDELAY_EN, 0);
    chk("rst_drst", bus.oDELAY_RST, 0);
    chk("rst_result", bus.oRESULT_MS, 0);
    chk("rst_fs", bus.oFALSE_START, 0);
    chk("rst_to", bus.oTIMEOUT, 0);
    chk("rst_best", bus.oBEST_MS, BEST_NONE);
  endtask

  task automatic run_round(input vec_t v);
    int   cyc;
    logic led_w;
    int   best;
    best = BEST_ON ? v.exp_best : BEST_NONE;
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    // ARM cycle
    chk("arm_en", bus.oDELAY_EN, 1);
    chk("arm_busy", bus.oBUSY, 1);
    chk("arm_result", bus.oRESULT_MS, 0);
    chk("arm_fs", bus.oFALSE_START, 0);
    chk("arm_to", bus.oTIMEOUT, 0);
    tick();
    chk("wait_en", bus.oDELAY_EN, 0);
    led_w = 1'b0;
    for (int i = 0; i < v.d; i++) begin
      led_w |= bus.oLED;
      tick();
    end
    led_w |= bus.oLED;
    if (v.mode == 1 || v.mode == 2) begin
      bus.iREACT = 1'b1;
      bus.iDELAY_DONE = (v.mode == 2);
      tick();
      bus.iREACT = 1'b0;
      bus.iDELAY_DONE = 1'b0;
      chk("done_drst", bus.oDELAY_RST, 1);
    end else begin
      bus.iDELAY_DONE = 1'b1;
      tick();
      bus.iDELAY_DONE = 1'b0;
      chk("go_led", bus.oLED, 1);
      if (v.mode == 0) begin
        for (int i = 0; i < v.r; i++) tick();
        bus.iREACT = 1'b1;
        tick();
        bus.iREACT = 1'b0;
      end else begin
        cyc = 0;
        while (!bus.oRESULT_VALID && cyc < 12000) begin
          tick();
          cyc++;
        end
        chk("timeout_cycles", cyc, 9991);
      end
      chk("done_drst", bus.oDELAY_RST, 0);
    end
    chk("wait_led", led_w, 0);
    // DONE cycle
    chk("done_valid", bus.oRESULT_VALID, 1);
    chk("done_led", bus.oLED, 0);
    chk("done_busy", bus.oBUSY, 1);
    chk("done_result", bus.oRESULT_MS, v.exp_res);
    chk("done_fs", bus.oFALSE_START, v.exp_fs);
    chk("done_to", bus.oTIMEOUT, v.exp_to);
    tick();
    // back in IDLE: pulses gone, result and flags held
    chk("idle_valid", bus.oRESULT_VALID, 0);
    chk("idle_busy", bus.oBUSY, 0);
    chk("idle_drst", bus.oDELAY_RST, 0);
    chk("idle_result", bus.oRESULT_MS, v.exp_res);
    chk("idle_fs", bus.oFALSE_START, v.exp_fs);
    chk("idle_to", bus.oTIMEOUT, v.exp_to);
    chk("idle_best", bus.oBEST_MS, best);
  endtask

  vec_t vecs[10];
  vec_t clean;

  initial begin
    //         d  mode     r   res fs to best(macro on)
    vecs = '{
      '{40, 0, 3000, 300, 0, 0, 300},
      '{ 5, 0, 2000, 200, 0, 0, 200},
      '{ 3, 1,    0,   0, 1, 0, 200},
      '{ 1, 0, 4005, 400, 0, 0, 200},
      '{40, 0, 2500, 250, 0, 0, 200},
      '{ 0, 0,    9,   0, 0, 0,   0},
      '{ 2, 2,    0,   0, 1, 0,   0},
      '{ 2, 0, 9990, 999, 0, 0,   0},
      '{ 7, 0, 9989, 998, 0, 0,   0},
      '{ 2, 3,    0, 999, 0, 1,   0}
    };
    clean = '{4, 0, 1234, 123, 0, 0, 123};

    bus.iSTART = 1'b0;
    bus.iREACT = 1'b0;
    bus.iDELAY_DONE = 1'b0;
    #2;
    check_reset_outputs();
    tick();
    tick();
    rst = 1'b0;

    // iREACT in IDLE is ignored
    bus.iREACT = 1'b1;
    tick();
    bus.iREACT = 1'b0;
    chk("idle_react_busy", bus.oBUSY, 0);
    chk("idle_react_valid", bus.oRESULT_VALID, 0);

    for (int i = 0; i < 10; i++) begin
      cur = i + 1;
      run_round(vecs[i]);
    end

    // Async reset in IDLE after a timeout round: outputs clear without a clock edge
    cur = 100;
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    tick();
    rst = 1'b0;

    // Async reset while GO is lit; iSTART is ignored mid-round
    cur = 101;
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    tick();
    tick();
    bus.iDELAY_DONE = 1'b1;
    tick();
    bus.iDELAY_DONE = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    chk("go_start_led", bus.oLED, 1);
    chk("go_start_en", bus.oDELAY_EN, 0);
    chk("go_start_busy", bus.oBUSY, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("go_rst_led", bus.oLED, 0);
    chk("go_rst_busy", bus.oBUSY, 0);
    chk("go_rst_best", bus.oBEST_MS, BEST_NONE);
    tick();
    rst = 1'b0;

    cur = 102;
    run_round(clean);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
